// File: rtl/score_bcd_display_pkg.sv
// Shared types and constants for the score display driver.
// Holds the converter FSM states and the 7-segment code table.
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        UPDATE
    } state_t;

    // Active-high segment codes, bit order gfe_dcba
    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/score_bcd_display_if.sv
// Score display bus: value/load request in, status and display data out.
// Ports: value, load (to driver); busy, done, overflow, bcd, hex (from driver).
interface score_bcd_display_if #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
);
    logic [BIN_W-1:0]    value;
    logic                load;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [4*DIGITS-1:0] bcd;
    logic [7*DIGITS-1:0] hex;

    modport master (
        output value, load,
        input  busy, done, overflow, bcd, hex
    );

    modport slave (
        input  value, load,
        output busy, done, overflow, bcd, hex
    );
endinterface

// File: rtl/score_bcd_display_seg7.sv
// Combinational BCD digit to 7-segment decoder (gfe_dcba).
// Ports: digit[3:0], blank, active_low in; seg[6:0] out.
module seg7_decode
    import score_disp_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       active_low,
    output logic [6:0] seg
);
    logic [6:0] seg_hi;

    always_comb begin
        seg_hi = SEG_BLANK;
        if (!blank) begin
            for (int i = 0; i < 10; i++) begin
                if (digit == 4'(i)) seg_hi = SEG_LUT[i];
            end
        end
        seg = active_low ? ~seg_hi : seg_hi;
    end
endmodule

// File: rtl/score_bcd_display.sv
// Sequential double-dabble score converter driving DIGITS 7-seg displays.
// Ports: clk, reset (async, high); bus (slave): value/load in, busy/done/overflow/bcd/hex out.
module score_bcd_display
    import score_disp_pkg::*;
#(
    parameter int BIN_W      = 20,
    parameter int DIGITS     = 6,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ   = 1'b1
) (
    input logic clk,
    input logic reset,
    score_bcd_display_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int HW = 7 * DIGITS;
    localparam int CW = $clog2(BIN_W);
    localparam logic [6:0] OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t            state, state_nx;
    logic              start;
    logic [BIN_W-1:0]  start_val;
    logic [BIN_W-1:0]  shreg, pend_val;
    logic              pending, ovf_acc;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     acc, acc_adj, res_bcd;
    logic [DIGITS-1:0] blank;
    logic              lead_zero;
    logic [HW-1:0]     hex_nx;

    logic              busy_q, done_q, ovf_q;
    logic [BW-1:0]     bcd_q;
    logic [HW-1:0]     hex_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // A load seen in UPDATE is the newest request, so it beats pend_val.
    always_comb begin
        state_nx  = state;
        start     = 1'b0;
        start_val = bus.value;
        unique case (state)
            IDLE: begin
                if (bus.load) begin
                    start    = 1'b1;
                    state_nx = CONV;
                end
            end
            CONV: begin
                if (cnt == CW'(BIN_W - 1)) state_nx = UPDATE;
            end
            UPDATE: begin
                if (bus.load) begin
                    start    = 1'b1;
                    state_nx = CONV;
                end else if (pending) begin
                    start     = 1'b1;
                    start_val = pend_val;
                    state_nx  = CONV;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        acc_adj = acc;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            pending  <= 1'b0;
            pend_val <= '0;
        end else begin
            if (start) begin
                shreg   <= start_val;
                acc     <= '0;
                cnt     <= '0;
                ovf_acc <= 1'b0;
            end else if (state == CONV) begin
                acc     <= {acc_adj[BW-2:0], shreg[BIN_W-1]};
                shreg   <= {shreg[BIN_W-2:0], 1'b0};
                // A carry out of the top digit means the score needs more digits
                ovf_acc <= ovf_acc | acc_adj[BW-1];
                cnt     <= cnt + CW'(1);
            end
            if (state == UPDATE) begin
                pending <= 1'b0;
            end else if (state == CONV && bus.load) begin
                pending  <= 1'b1;
                pend_val <= bus.value;
            end
        end
    end

    assign res_bcd = ovf_acc ? {DIGITS{4'h9}} : acc;

    // Saturated results are all nines, so they never blank.
    always_comb begin
        blank     = '0;
        lead_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead_zero = lead_zero & (res_bcd[4*k +: 4] == 4'h0);
            blank[k]  = BLANK_LZ & lead_zero;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seg7_decode u_seg (
            .digit      (res_bcd[4*g +: 4]),
            .blank      (blank[g]),
            .active_low (ACTIVE_LOW),
            .seg        (hex_nx[7*g +: 7])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            bcd_q  <= '0;
            hex_q  <= {DIGITS{OFF}};
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state == UPDATE);
            if (state == UPDATE) begin
                bcd_q <= res_bcd;
                hex_q <= hex_nx;
                ovf_q <= ovf_acc;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = ovf_q;
    assign bus.bcd      = bcd_q;
    assign bus.hex      = hex_q;

endmodule

// File: tb/tb_score_bcd_display.sv
// Self-checking bench for score_bcd_display: three parameter variants, one reference model.
// Ports: none (top-level bench).
module tb_score_bcd_display;

    localparam int LAT = 21;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [19:0] value;

    int unsigned vec  = 0;
    int unsigned miss = 0;
    int          cyc  = 0;

    always #5 clk = ~clk;

    score_bcd_display_if #(.BIN_W(20), .DIGITS(6)) i0 ();
    score_bcd_display_if #(.BIN_W(20), .DIGITS(6)) i1 ();
    score_bcd_display_if #(.BIN_W(20), .DIGITS(6)) i2 ();

    assign i0.value = value;
    assign i0.load  = load;
    assign i1.value = value;
    assign i1.load  = load;
    assign i2.value = value;
    assign i2.load  = load;

    score_bcd_display #(.BIN_W(20), .DIGITS(6), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1))
        dut0 (.clk(clk), .reset(reset), .bus(i0));
    score_bcd_display #(.BIN_W(20), .DIGITS(6), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0))
        dut1 (.clk(clk), .reset(reset), .bus(i1));
    score_bcd_display #(.BIN_W(20), .DIGITS(6), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b1))
        dut2 (.clk(clk), .reset(reset), .bus(i2));

    logic [6:0] segtab [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic int unsigned digit_of(int unsigned v, int k);
        int unsigned p;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return (v > 999999) ? 9 : (v / p) % 10;
    endfunction

    function automatic logic [23:0] m_bcd(int unsigned v);
        logic [23:0] r;
        r = '0;
        for (int k = 0; k < 6; k++) r[4*k +: 4] = 4'(digit_of(v, k));
        return r;
    endfunction

    function automatic logic [41:0] m_hex(int unsigned v, bit al, bit blz);
        logic [41:0] r;
        logic [6:0]  s;
        int          hi;
        r  = '0;
        hi = 0;
        for (int k = 0; k < 6; k++) if (digit_of(v, k) != 0) hi = k;
        for (int k = 0; k < 6; k++) begin
            s = (blz && k > hi) ? 7'h00 : segtab[digit_of(v, k)];
            if (al) s = ~s;
            r[7*k +: 7] = s;
        end
        return r;
    endfunction

    // Reference model: each request completes LAT cycles after it starts;
    // loads during a conversion collapse to the latest one.
    bit          act, pend;
    int          rem;
    int unsigned cur, pv;
    logic        e_busy, e_done, e_ovf;
    logic [23:0] e_bcd;
    logic [41:0] e_hex [3];

    task automatic show(int unsigned v);
        e_bcd    = m_bcd(v);
        e_ovf    = (v > 999999);
        e_hex[0] = m_hex(v, 1'b1, 1'b1);
        e_hex[1] = m_hex(v, 1'b1, 1'b0);
        e_hex[2] = m_hex(v, 1'b0, 1'b1);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            act      = 0;
            pend     = 0;
            e_busy   = 0;
            e_done   = 0;
            e_ovf    = 0;
            e_bcd    = '0;
            e_hex[0] = {6{7'h7F}};
            e_hex[1] = {6{7'h7F}};
            e_hex[2] = {6{7'h00}};
        end else begin
            e_done = 0;
            if (act) begin
                rem--;
                if (rem == 0) begin
                    show(cur);
                    e_done = 1;
                    if (load) begin
                        cur = value;
                        rem = LAT;
                    end else if (pend) begin
                        cur  = pv;
                        pend = 0;
                        rem  = LAT;
                    end else begin
                        act = 0;
                    end
                end else if (load) begin
                    pend = 1;
                    pv   = value;
                end
            end else if (load) begin
                act = 1;
                cur = value;
                rem = LAT;
            end
            e_busy = act;
        end
    end

    task automatic chk(string name, logic [63:0] act_v, logic [63:0] exp_v);
        vec++;
        if (act_v !== exp_v) begin
            miss++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    always @(posedge clk) begin
        #2;
        chk("busy", 64'(i0.busy), 64'(e_busy));
        chk("done", 64'(i0.done), 64'(e_done));
        chk("overflow", 64'(i0.overflow), 64'(e_ovf));
        chk("bcd", 64'(i0.bcd), 64'(e_bcd));
        chk("hex_al_blz", 64'(i0.hex), 64'(e_hex[0]));
        chk("hex_al_noblz", 64'(i1.hex), 64'(e_hex[1]));
        chk("hex_ah_blz", 64'(i2.hex), 64'(e_hex[2]));
        chk("bcd_dut1", 64'(i1.bcd), 64'(e_bcd));
        chk("done_dut2", 64'(i2.done), 64'(e_done));
    end

    int t0;

    task automatic issue(int unsigned v);
        @(negedge clk);
        value = 20'(v);
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        t0    = cyc;
    endtask

    task automatic wait_done(output int d);
        d = -1;
        for (int n = 0; n < 80; n++) begin
            @(posedge clk);
            #2;
            if (i0.done) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) begin
            vec++;
            miss++;
            $display("FAIL done_timeout: no done within 80 cycles (cycle %0d)", cyc);
        end
    endtask

    int d;

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 64'(i0.busy), 64'h0);
        chk("rst_hex", 64'(i0.hex), 64'({6{7'h7F}}));
        reset = 1'b0;

        issue(123456);
        wait_done(d);
        chk("lat_123456", 64'(d - t0), 64'(LAT));
        chk("bcd_123456", 64'(i0.bcd), 64'h123456);
        chk("hex0_6", 64'(i0.hex[6:0]), 64'h02);
        chk("hex5_1", 64'(i0.hex[41:35]), 64'h79);
        chk("ovf_123456", 64'(i0.overflow), 64'h0);

        issue(777);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rstmid_busy", 64'(i0.busy), 64'h0);
        chk("rstmid_done", 64'(i0.done), 64'h0);
        chk("rstmid_hex", 64'(i0.hex), 64'({6{7'h7F}}));
        chk("rstmid_bcd", 64'(i0.bcd), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("rstmid_after", 64'(i0.hex), 64'({6{7'h7F}}));

        issue(0);
        wait_done(d);
        chk("zero_blz", 64'(i0.hex), 64'({{5{7'h7F}}, 7'h40}));
        chk("zero_noblz", 64'(i1.hex), 64'({6{7'h40}}));
        issue(42);
        wait_done(d);
        chk("v42_blz", 64'(i0.hex), 64'({{4{7'h7F}}, 7'h19, 7'h24}));
        chk("v42_noblz", 64'(i1.hex), 64'({{4{7'h40}}, 7'h19, 7'h24}));
        chk("v42_bcd", 64'(i0.bcd), 64'h42);

        issue(20'hFFFFF);
        wait_done(d);
        chk("max_ovf", 64'(i0.overflow), 64'h1);
        chk("max_bcd", 64'(i0.bcd), 64'h999999);
        chk("max_hex", 64'(i0.hex), 64'({6{7'h10}}));
        issue(999999);
        wait_done(d);
        chk("999999_ovf", 64'(i0.overflow), 64'h0);
        chk("999999_bcd", 64'(i0.bcd), 64'h999999);
        issue(1000000);
        wait_done(d);
        chk("1e6_ovf", 64'(i0.overflow), 64'h1);

        issue(5);
        @(negedge clk);
        @(negedge clk);
        value = 20'd7;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        @(negedge clk);
        value = 20'd8;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_done(d);
        chk("b2b_first_t", 64'(d - t0), 64'(LAT));
        chk("b2b_first_v", 64'(i0.bcd), 64'h5);
        wait_done(d);
        chk("b2b_second_t", 64'(d - t0), 64'(2 * LAT));
        chk("b2b_second_v", 64'(i0.bcd), 64'h8);

        issue(8);
        wait_done(d);
        chk("ah_8", 64'(i2.hex), 64'({{5{7'h00}}, 7'h7F}));

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            reset = ($urandom % 400 == 0);
            load  = ($urandom % 9 == 0);
            case ($urandom % 4)
                0: value = 20'($urandom_range(0, 99));
                1: value = 20'($urandom_range(0, 20'hFFFFF));
                2: value = 20'($urandom_range(999990, 1000010));
                default: value = 20'($urandom_range(0, 999999));
            endcase
        end
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        repeat (50) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
